// File: rtl/synapse_weight_store.sv
// Synapse weight store: byte-column integer RAM, rich-club decimal table, 2-cycle read pipeline.
// Define SYN_LFSR_EN to source non-rich-club decimal parts from a 16-bit Galois LFSR.
module synapse_weight_store #(
   parameter int ADDR_W   = 7,
   parameter int NUM_COL  = 4,
   parameter int INT_W    = 8,
   parameter int DECI_W   = 8,
   parameter int RC_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      kill,
   input  logic [ADDR_W-1:0]         i_addr,
   input  logic [INT_W+DECI_W-1:0]   w_data,
   input  logic                      w_en,
   input  logic                      rc_load,
   input  logic                      r_en,
   output logic [INT_W+DECI_W-1:0]   weight_out,
   output logic                      weight_valid,
   output logic                      rc_full,
   output logic                      busy
);
   localparam int COL_W = $clog2(NUM_COL);
   localparam int ROW_W = ADDR_W - COL_W;
   localparam int ROWS  = 1 << ROW_W;
   localparam int W_W   = INT_W + DECI_W;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [ROW_W-1:0]         clr_row_q, clr_row_d;
   logic                     idle, kill_acc, wr_acc, rc_acc, rd_acc;
   logic [ROW_W-1:0]         req_row;
   logic [COL_W-1:0]         req_col;

   assign req_row = i_addr[ADDR_W-1:COL_W];
   assign req_col = i_addr[COL_W-1:0];

   always_comb begin
      idle     = (state_q == IDLE);
      kill_acc = idle & kill;
      wr_acc   = idle & ~kill & w_en;
      rc_acc   = idle & ~kill & ~w_en & rc_load;
      rd_acc   = idle & ~kill & ~w_en & ~rc_load & r_en;
   end

   always_comb begin
      state_d   = state_q;
      clr_row_d = clr_row_q;
      if (state_q == IDLE) begin
         if (kill_acc) begin
            state_d   = CLEAR;
            clr_row_d = '0;
         end
      end else begin
         clr_row_d = clr_row_q + 1'b1;
         if (clr_row_q == '1) state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         clr_row_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_row_q <= clr_row_d;
      end
   end

   // The sweep owns every column of its row; a normal write enables one column only.
   logic [NUM_COL-1:0]       mem_we;
   logic [ROW_W-1:0]         mem_row;
   logic [INT_W-1:0]         mem_wdata;
   logic [NUM_COL*INT_W-1:0] rd_row;

   always_comb begin
      mem_we    = '0;
      mem_row   = req_row;
      mem_wdata = w_data[W_W-1 -: INT_W];
      if (state_q == CLEAR) begin
         mem_we    = '1;
         mem_row   = clr_row_q;
         mem_wdata = '0;
      end else if (wr_acc) begin
         mem_we[req_col] = 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_col
         logic [INT_W-1:0] mem [ROWS];
         logic [INT_W-1:0] rd_q;
         always_ff @(posedge clk) begin
            if (mem_we[gi]) mem[mem_row] <= mem_wdata;
            if (rd_acc)     rd_q <= mem[req_row];
         end
         assign rd_row[gi*INT_W +: INT_W] = rd_q;
      end
   endgenerate

   logic [RC_DEPTH-1:0] rc_valid_q, rc_valid_d, req_hit, s1_hit, free_sel;
   logic [ADDR_W-1:0]   rc_addr_q [RC_DEPTH];
   logic [ADDR_W-1:0]   rc_addr_d [RC_DEPTH];
   logic [DECI_W-1:0]   rc_deci_q [RC_DEPTH];
   logic [DECI_W-1:0]   rc_deci_d [RC_DEPTH];
   logic                s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;

   generate
      for (genvar gi = 0; gi < RC_DEPTH; gi++) begin : g_rc_hit
         assign req_hit[gi] = rc_valid_q[gi] && (rc_addr_q[gi] == i_addr);
         assign s1_hit[gi]  = rc_valid_q[gi] && (rc_addr_q[gi] == s1_addr_q);
      end
   endgenerate

   // Lowest clear bit of the valid vector picks the free slot.
   assign free_sel = ~rc_valid_q & (rc_valid_q + 1'b1);

   always_comb begin
      rc_valid_d = rc_valid_q;
      rc_addr_d  = rc_addr_q;
      rc_deci_d  = rc_deci_q;
      for (int i = 0; i < RC_DEPTH; i++) begin
         if (kill_acc) begin
            rc_valid_d[i] = 1'b0;
         end else if ((wr_acc | rc_acc) & req_hit[i]) begin
            rc_deci_d[i] = w_data[DECI_W-1:0];
         end else if (rc_acc & ~(|req_hit) & free_sel[i]) begin
            rc_valid_d[i] = 1'b1;
            rc_addr_d[i]  = i_addr;
            rc_deci_d[i]  = w_data[DECI_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rc_valid_q <= '0;
      else     rc_valid_q <= rc_valid_d;
      rc_addr_q <= rc_addr_d;
      rc_deci_q <= rc_deci_d;
   end

   logic [DECI_W-1:0] rnd_deci;
`ifdef SYN_LFSR_EN
   logic [15:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end
   assign rnd_deci = lfsr_q[DECI_W-1:0];
`else
   assign rnd_deci = '0;
`endif

   logic [W_W-1:0]    weight_out_q, weight_out_d;
   logic              weight_valid_q, weight_valid_d;
   logic [DECI_W-1:0] s1_deci;
   logic [INT_W-1:0]  s1_int;
   int                s1_col;

   // Second stage: column select, rich-club lookup and random sample happen here.
   always_comb begin
      s1_valid_d = rd_acc;
      s1_addr_d  = rd_acc ? i_addr : s1_addr_q;
      s1_deci    = rnd_deci;
      for (int i = 0; i < RC_DEPTH; i++) begin
         if (s1_hit[i]) s1_deci = rc_deci_q[i];
      end
      s1_col         = int'(s1_addr_q[COL_W-1:0]);
      s1_int         = rd_row[s1_col*INT_W +: INT_W];
      weight_valid_d = s1_valid_q;
      weight_out_d   = '0;
      if (s1_valid_q && (s1_addr_q != '0)) weight_out_d = {s1_int, s1_deci};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q     <= 1'b0;
         s1_addr_q      <= '0;
         weight_valid_q <= 1'b0;
         weight_out_q   <= '0;
      end else begin
         s1_valid_q     <= s1_valid_d;
         s1_addr_q      <= s1_addr_d;
         weight_valid_q <= weight_valid_d;
         weight_out_q   <= weight_out_d;
      end
   end

   assign weight_out   = weight_out_q;
   assign weight_valid = weight_valid_q;
   assign rc_full      = &rc_valid_q;
   assign busy         = (state_q == CLEAR);
endmodule

// File: tb/tb_synapse_weight_store.sv
// Directed plus randomized bench for synapse_weight_store against a map-based reference model.
module tb_synapse_weight_store;
   localparam int ADDR_W = 7, NUM_COL = 4, INT_W = 8, DECI_W = 8, RC_DEPTH = 4;
   localparam int ROWS = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1, kill = 1'b0, w_en = 1'b0, rc_load = 1'b0, r_en = 1'b0;
   logic [6:0]  i_addr = '0;
   logic [15:0] w_data = '0;
   logic [15:0] weight_out;
   logic        weight_valid, rc_full, busy;

   synapse_weight_store #(
      .ADDR_W(ADDR_W), .NUM_COL(NUM_COL), .INT_W(INT_W), .DECI_W(DECI_W), .RC_DEPTH(RC_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .kill(kill), .i_addr(i_addr), .w_data(w_data),
      .w_en(w_en), .rc_load(rc_load), .r_en(r_en), .weight_out(weight_out),
      .weight_valid(weight_valid), .rc_full(rc_full), .busy(busy)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  mem_m [128];
   logic [7:0]  rc_m [int];
   int          busy_m = 0;
   logic [15:0] lfsr_m = 16'hACE1;
   logic        p1_v = 1'b0, o_v = 1'b0;
   logic [15:0] p1_d = '0, o_d = '0;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   task automatic check(input string tag);
      total++;
      assert (weight_valid === o_v) else begin
         bad++; $error("FAIL %s weight_valid got %0b want %0b", tag, weight_valid, o_v);
      end
      total++;
      assert (weight_out === o_d) else begin
         bad++; $error("FAIL %s weight_out got %h want %h", tag, weight_out, o_d);
      end
      total++;
      assert (busy === (busy_m != 0)) else begin
         bad++; $error("FAIL %s busy got %0b want %0b", tag, busy, busy_m != 0);
      end
      total++;
      assert (rc_full === (rc_m.num() == RC_DEPTH)) else begin
         bad++; $error("FAIL %s rc_full got %0b want %0b", tag, rc_full, rc_m.num() == RC_DEPTH);
      end
   endtask

   task automatic expect_out(input string tag, input logic [15:0] want);
      total++;
      assert (weight_valid === 1'b1 && weight_out === want) else begin
         bad++; $error("FAIL %s valid/out got %0b/%h want 1/%h", tag, weight_valid, weight_out, want);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1; kill = 1'b0; w_en = 1'b0; rc_load = 1'b0; r_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      rc_m.delete();
      busy_m = 0; lfsr_m = 16'hACE1;
      p1_v = 1'b0; p1_d = '0; o_v = 1'b0; o_d = '0;
      check(tag);
   endtask

   task automatic tick(input string tag, input logic k, input logic we, input logic rl,
                       input logic re, input logic [6:0] a, input logic [15:0] d);
      logic        nv, kacc;
      logic [15:0] nd, nxt;
      logic [7:0]  deci;
      int          row;
      kill = k; w_en = we; rc_load = rl; r_en = re; i_addr = a; w_data = d;
      nv = 1'b0; nd = '0; kacc = 1'b0;
      nxt = lfsr_next(lfsr_m);
      if (busy_m != 0) begin
         row = ROWS - busy_m;
         for (int c = 0; c < NUM_COL; c++) mem_m[row*NUM_COL + c] = 8'h00;
      end else if (k) begin
         kacc = 1'b1;
         rc_m.delete();
      end else if (we) begin
         mem_m[a] = d[15:8];
         if (rc_m.exists(int'(a))) rc_m[int'(a)] = d[7:0];
      end else if (rl) begin
         if (rc_m.exists(int'(a)) || rc_m.num() < RC_DEPTH) rc_m[int'(a)] = d[7:0];
      end else if (re) begin
         nv = 1'b1;
`ifdef SYN_LFSR_EN
         deci = nxt[7:0];
`else
         deci = 8'h00;
`endif
         if (rc_m.exists(int'(a))) deci = rc_m[int'(a)];
         nd = (a == 7'd0) ? 16'h0000 : {mem_m[a], deci};
      end
      @(posedge clk); #1;
      lfsr_m = nxt;
      o_v = p1_v; o_d = p1_d; p1_v = nv; p1_d = nd;
      if (busy_m != 0) busy_m--;
      else if (kacc) busy_m = ROWS;
      check(tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick("idle", 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
   endtask

   initial begin
      int bc;
      logic [6:0] ra;
      do_reset("reset");

      // Clear sweep with a write one cycle after kill
      tick("kill", 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
      bc = 0;
      while (busy && bc < 100) begin
         bc++;
         if (bc == 1) tick("kill_wr", 1'b0, 1'b1, 1'b0, 1'b0, 7'd3, 16'hAB00);
         else         tick("sweep", 1'b0, 1'b0, 1'b0, 1'b1, 7'd5, 16'h0);
      end
      total++;
      assert (bc == 32) else begin bad++; $error("FAIL sweep_len got %0d want 32", bc); end
      tick("rd_clr3", 1'b0, 1'b0, 1'b0, 1'b1, 7'd3, 16'h0);
      tick("rd_clr100", 1'b0, 1'b0, 1'b0, 1'b1, 7'd100, 16'h0);
      idle(2);

      // Column-selective write
      do_reset("reset2");
      tick("wr4", 1'b0, 1'b1, 1'b0, 1'b0, 7'd4, 16'h1100);
      tick("wr6", 1'b0, 1'b1, 1'b0, 1'b0, 7'd6, 16'h2200);
      tick("wr7", 1'b0, 1'b1, 1'b0, 1'b0, 7'd7, 16'h3300);
      tick("wr5", 1'b0, 1'b1, 1'b0, 1'b0, 7'd5, 16'h3C00);
      tick("rd5", 1'b0, 1'b0, 1'b0, 1'b1, 7'd5, 16'h0);
      tick("rd4", 1'b0, 1'b0, 1'b0, 1'b1, 7'd4, 16'h0);
      total++;
      assert (weight_valid === 1'b1 && weight_out[15:8] === 8'h3C) else begin
         bad++; $error("FAIL rd5_int got %h want 3c", weight_out[15:8]);
      end
      tick("rd6", 1'b0, 1'b0, 1'b0, 1'b1, 7'd6, 16'h0);
      tick("rd7", 1'b0, 1'b0, 1'b0, 1'b1, 7'd7, 16'h0);
      idle(2);

      // Rich-club load then write-through
      tick("rc9", 1'b0, 1'b0, 1'b1, 1'b0, 7'd9, 16'h007F);
      tick("wr9", 1'b0, 1'b1, 1'b0, 1'b0, 7'd9, 16'h1280);
      tick("rd9", 1'b0, 1'b0, 1'b0, 1'b1, 7'd9, 16'h0);
      idle(1);
      expect_out("rd9_val", 16'h1280);
      idle(1);

      // Fill the table; fifth load is dropped, existing entry still overwritable
      tick("wr23", 1'b0, 1'b1, 1'b0, 1'b0, 7'd23, 16'h5500);
      tick("rc20", 1'b0, 1'b0, 1'b1, 1'b0, 7'd20, 16'h0021);
      tick("rc21", 1'b0, 1'b0, 1'b1, 1'b0, 7'd21, 16'h0022);
      tick("rc22", 1'b0, 1'b0, 1'b1, 1'b0, 7'd22, 16'h0033);
      tick("rc23", 1'b0, 1'b0, 1'b1, 1'b0, 7'd23, 16'h0044);
      tick("rc20b", 1'b0, 1'b0, 1'b1, 1'b0, 7'd20, 16'h0099);
      tick("rd23", 1'b0, 1'b0, 1'b0, 1'b1, 7'd23, 16'h0);
      tick("rd20", 1'b0, 1'b0, 1'b0, 1'b1, 7'd20, 16'h0);
      idle(2);

      // Back-to-back reads including address 0
      tick("rd1", 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 16'h0);
      tick("rd2", 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 16'h0);
      tick("rd3", 1'b0, 1'b0, 1'b0, 1'b1, 7'd3, 16'h0);
      tick("rd0", 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 16'h0);
      idle(1);
      expect_out("rd0_zero", 16'h0000);
      idle(1);

      // Priority: write wins over rc_load and read; kill wins over all
      tick("prio_wr", 1'b0, 1'b1, 1'b1, 1'b1, 7'd30, 16'h6677);
      tick("prio_rd", 1'b0, 1'b0, 1'b0, 1'b1, 7'd30, 16'h0);
      // Read in flight survives a kill on the next cycle
      tick("prio_kill", 1'b1, 1'b1, 1'b1, 1'b1, 7'd31, 16'h7788);
      idle(ROWS + 2);
      tick("rd30", 1'b0, 1'b0, 1'b0, 1'b1, 7'd30, 16'h0);
      idle(2);

      // Reset aborts a sweep part-way
      tick("kill2", 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
      for (int i = 0; i < 40; i++) tick("wr_all", 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
      for (int i = 0; i < 8; i++) tick("fill", 1'b0, 1'b1, 1'b0, 1'b0, 7'(i * 16 + 1), 16'hA500 + 16'(i));
      tick("kill3", 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
      idle(5);
      do_reset("reset_abort");
      for (int i = 0; i < 8; i++) tick("rd_part", 1'b0, 1'b0, 1'b0, 1'b1, 7'(i * 16 + 1), 16'h0);
      idle(2);

      // First read after reset samples the LFSR one step past the seed
      do_reset("reset3");
      tick("rd1_lfsr", 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 16'h0);
      idle(2);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
         ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
         tick("rand", $urandom_range(0, 79) == 0, $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 5, ra, 16'($urandom));
      end
      idle(ROWS + 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
